// File: rtl/mmc1_pkg.sv
// mmc1_pkg: shared MMC1 register encodings, bus constants and writer state type
package mmc1_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;
  localparam logic [15:0] MMC1_BASE_ADDR = 16'h8000;
  localparam logic [7:0]  MMC1_RST_DATA  = 8'h80;
  typedef enum logic [2:0] {IDLE, RST_WR, RST_GAP, BIT_WR, BIT_GAP, END_GAP} wr_state_t;
  function automatic logic [15:0] reg_addr(input logic [1:0] sel);
    return MMC1_BASE_ADDR | {1'b0, sel, 13'b0};
  endfunction
endpackage

// File: rtl/mmc1_gap_timer.sv
// mmc1_gap_timer: loadable 4-bit down-counter, expired when it reaches zero
module mmc1_gap_timer (
  input  logic       ck,
  input  logic       res,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_expired
);
  logic [3:0] r_cnt;
  always_ff @(posedge ck)
    if (res) r_cnt <= '0;
    else r_cnt <= i_load ? i_val : (r_cnt != '0 ? r_cnt - 4'd1 : r_cnt);
  assign o_expired = r_cnt == '0;
endmodule

// File: rtl/mmc1_serial_writer.sv
// mmc1_serial_writer: issues the MMC1 serial load sequence (optional reset write, 5 bits LSB first)
module mmc1_serial_writer import mmc1_pkg::*; #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        ck,
  input  logic        res,
  input  logic        req,
  input  logic [1:0]  reg_sel,
  input  logic [4:0]  data,
  input  logic        reset_first,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        busy,
  output logic        done
);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  wr_state_t r_state, w_next;
  logic [1:0] r_sel, w_sel;
  logic [4:0] r_data, w_data;
  logic [2:0] r_bit, w_idx;
  logic       w_load, w_expired;
  // every write state arms the timer so the following gap lasts GAP_CYCLES
  assign w_load = r_state == RST_WR || r_state == BIT_WR;
  mmc1_gap_timer u_gap (
    .ck(ck), .res(res), .i_load(w_load), .i_val(GAP_LOAD), .o_expired(w_expired)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req ? (reset_first ? RST_WR : BIT_WR) : IDLE;
      RST_WR:  w_next = RST_GAP;
      RST_GAP: w_next = w_expired ? BIT_WR : RST_GAP;
      BIT_WR:  w_next = r_bit == 3'd4 ? END_GAP : BIT_GAP;
      BIT_GAP: w_next = w_expired ? BIT_WR : BIT_GAP;
      END_GAP: w_next = w_expired ? IDLE : END_GAP;
      default: w_next = IDLE;
    endcase
  end
  // the first strobe is registered on the accept edge, before the payload latch is visible
  assign w_sel  = r_state == IDLE ? reg_sel : r_sel;
  assign w_data = r_state == IDLE ? data : r_data;
  assign w_idx  = r_state == IDLE ? 3'd0 : r_bit;
  always_ff @(posedge ck) begin
    if (res) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_data   <= '0;
      r_bit    <= '0;
      bus_wr   <= 1'b0;
      bus_addr <= '0;
      bus_dout <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sel    <= w_sel;
      r_data   <= w_data;
      r_bit    <= r_state == IDLE ? 3'd0 : (r_state == BIT_WR ? r_bit + 3'd1 : r_bit);
      bus_wr   <= w_next == RST_WR || w_next == BIT_WR;
      bus_addr <= w_next == RST_WR ? MMC1_BASE_ADDR : (w_next == BIT_WR ? reg_addr(w_sel) : 16'h0);
      bus_dout <= w_next == RST_WR ? MMC1_RST_DATA : (w_next == BIT_WR ? {7'b0, w_data[w_idx]} : 8'h0);
      busy     <= w_next != IDLE;
      done     <= r_state == END_GAP && w_expired;
    end
  end
endmodule
